// File: rtl/iterative_multiplication.sv
// rtl/iterative_multiplication.sv - sign-magnitude multi-cycle multiplier, BITS_PER_CYCLE multiplier bits per clock
// Optional: define ITERATIVE_MULT_EARLY_TERMINATION_EN to finish as soon as the remaining multiplier bits are zero.
module iterative_multiplication #(
  parameter int OPERAND_WIDTH_IN_BITS = 64,
  parameter int PRODUCT_WIDTH_IN_BITS = 128,
  parameter int BITS_PER_CYCLE        = 4,
  parameter int TAG_WIDTH_IN_BITS     = 4
) (
  input  logic                             clk_in,
  input  logic                             reset_in,
  input  logic                             is_valid_in,
  output logic                             is_ready_out,
  input  logic                             multiplier_sign_bit_in,
  input  logic [OPERAND_WIDTH_IN_BITS-1:0] multiplier_in,
  input  logic                             multicand_sign_bit_in,
  input  logic [OPERAND_WIDTH_IN_BITS-1:0] multicand_in,
  input  logic [TAG_WIDTH_IN_BITS-1:0]     tag_in,
  output logic                             is_valid_out,
  input  logic                             is_ready_in,
  output logic                             product_sign_bit_out,
  output logic [PRODUCT_WIDTH_IN_BITS-1:0] product_out,
  output logic [TAG_WIDTH_IN_BITS-1:0]     tag_out
);

  localparam int W  = OPERAND_WIDTH_IN_BITS;
  localparam int P  = PRODUCT_WIDTH_IN_BITS;
  localparam int B  = BITS_PER_CYCLE;
  localparam int N  = W / B;
  localparam int CW = $clog2(N + 1);
  localparam int SW = $clog2(P);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                   state;
  logic [W-1:0]                 multicand;
  logic [W-1:0]                 shreg;
  logic [P-1:0]                 acc;
  logic [CW-1:0]                count;
  logic                         sign;
  logic [TAG_WIDTH_IN_BITS-1:0] tag;

  logic [W+B-1:0] pp_raw;
  logic [SW-1:0]  shamt;
  logic [P-1:0]   pp;
  logic [P-1:0]   acc_next;
  logic [W-1:0]   shreg_next;
  logic           last_iter;

  // One digit of the multiplier times the full multicand, placed at its digit position.
  always_comb begin
    pp_raw     = {{B{1'b0}}, multicand} * {{W{1'b0}}, shreg[B-1:0]};
    shamt      = SW'(count) * SW'(B);
    pp         = P'(pp_raw) << shamt;
    acc_next   = acc + pp;
    shreg_next = shreg >> B;
`ifdef ITERATIVE_MULT_EARLY_TERMINATION_EN
    last_iter  = (count == CW'(N - 1)) || (shreg_next == '0);
`else
    last_iter  = (count == CW'(N - 1));
`endif
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state                <= IDLE;
      multicand            <= '0;
      shreg                <= '0;
      acc                  <= '0;
      count                <= '0;
      sign                 <= 1'b0;
      tag                  <= '0;
      is_ready_out         <= 1'b0;
      is_valid_out         <= 1'b0;
      product_sign_bit_out <= 1'b0;
      product_out          <= '0;
      tag_out              <= '0;
    end else begin
      case (state)
        IDLE: begin
          is_ready_out <= 1'b1;
          if (is_valid_in && is_ready_out) begin
            multicand    <= multicand_in;
            shreg        <= multiplier_in;
            tag          <= tag_in;
            sign         <= multiplier_sign_bit_in ^ multicand_sign_bit_in;
            acc          <= '0;
            count        <= '0;
            is_ready_out <= 1'b0;
            state        <= BUSY;
          end
        end
        BUSY: begin
          acc   <= acc_next;
          shreg <= shreg_next;
          count <= count + CW'(1);
          if (last_iter) begin
            state                <= DONE;
            is_valid_out         <= 1'b1;
            product_out          <= acc_next;
            // A zero magnitude is always reported as positive.
            product_sign_bit_out <= sign & (|acc_next);
            tag_out              <= tag;
          end
        end
        DONE: begin
          if (is_ready_in) begin
            state        <= IDLE;
            is_valid_out <= 1'b0;
            is_ready_out <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/iterative_multiplication.md
# iterative_multiplication

Parametrised sign-magnitude multi-cycle multiplier. It retires BITS_PER_CYCLE multiplier bits per clock and carries a request tag through to the result. It uses ready/valid handshakes on both the operand and product sides, with full output backpressure. It is the drop-in successor to the fixed-width fast multiplier in the execute-stage arithmetic units.

## Interface
- OPERAND_WIDTH_IN_BITS, 64, magnitude width of each operand.
- PRODUCT_WIDTH_IN_BITS, 128, product magnitude width; must equal 2 × OPERAND_WIDTH_IN_BITS.
- BITS_PER_CYCLE, 4, multiplier bits consumed per iteration; must divide OPERAND_WIDTH_IN_BITS. N = OPERAND_WIDTH_IN_BITS / BITS_PER_CYCLE.
- TAG_WIDTH_IN_BITS, 4, width of the opaque request tag.

Ports:
- clk_in  in  1  the single clock; all state updates on its rising edge.
- reset_in  in  1  asynchronous, active-low reset.
- is_valid_in  in  1  operands and tag are valid.
- is_ready_out  out  1  block can accept operands.
- multiplier_sign_bit_in  in  1  multiplier sign (1 = negative).
- multiplier_in  in  OPERAND_WIDTH_IN_BITS  multiplier magnitude.
- multicand_sign_bit_in  in  1  multicand sign.
- multicand_in  in  OPERAND_WIDTH_IN_BITS  multicand magnitude.
- tag_in  in  TAG_WIDTH_IN_BITS  request tag.
- is_valid_out  out  1  product is valid.
- is_ready_in  in  1  consumer accepts product.
- product_sign_bit_out  out  1  product sign.
- product_out  out  PRODUCT_WIDTH_IN_BITS  product magnitude.
- tag_out  out  TAG_WIDTH_IN_BITS  tag of the current product.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE.** is_ready_out = 1. On is_valid_in && is_ready_out:
  - latch the multicand, the multiplier (into a shift register) and the tag;
  - sign = XOR of the two sign bits;
  - clear the accumulator and the iteration counter;
  - go to BUSY.
- **BUSY.** Each iteration i (0..N-1):
  - accumulator += multicand × (low BITS_PER_CYCLE bits of the shift register), shifted left by i·BITS_PER_CYCLE;
  - shift register >>= BITS_PER_CYCLE;
  - counter increments.
- **Leaving BUSY.** After iteration N-1, go to DONE.
- **DONE.** is_valid_out = 1. product_out, product_sign_bit_out and tag_out are held stable until is_valid_out && is_ready_in; on that handshake go to IDLE.
- **Arithmetic.**
  - The product is exact: no truncation or overflow is possible at PRODUCT_WIDTH_IN_BITS.
  - If the product magnitude is zero, product_sign_bit_out = 0 (no negative zero).
- **No overlap.** is_ready_out = 0 in BUSY and DONE, so a new request is never accepted in the cycle a product is consumed.
- **Ignored inputs.** Operand inputs are ignored unless a handshake occurs; is_ready_in is ignored outside DONE.
- **Reset.** Asserting reset_in (low) at any time, including mid-BUSY or DONE, aborts the operation immediately:
  - state goes to IDLE;
  - the accumulator, product_out, product_sign_bit_out, tag_out, is_valid_out and is_ready_out all go to 0.

## Timing
- **Ready after reset.** is_ready_out is registered: it is 0 while reset is asserted and rises at the first rising edge after reset deassertion.
- **Latency.** If the operand handshake occurs at edge T0, BUSY iterations execute at edges T0+1 … T0+N. is_valid_out is high after edge T0+N, i.e. N cycles after acceptance (16 cycles at defaults).
- **Back-to-back.** Product handshake at edge T1 → is_ready_out = 1 after T1. The earliest next acceptance is T1+1. Minimum initiation interval is N+2 cycles.
- **Outputs.** All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- **ITERATIVE_MULT_EARLY_TERMINATION_EN defined:**
  - After each BUSY iteration, if the remaining multiplier shift register is zero, go directly to DONE.
  - Latency = max(1, ceil((index of multiplier MSB set + 1) / BITS_PER_CYCLE)) cycles; a zero multiplier takes 1 cycle.
  - Results are identical to the non-early-terminating build.
- **Not defined:** latency is always exactly N cycles, independent of the data.

## Test plan
- **Basic product.** Reset, then 7 × 2 with both signs 0 and tag 3 → after 16 cycles: is_valid_out = 1, product_out = 14, sign 0, tag_out = 3.
- **Signed sequence.** Each request is consumed immediately:
  - 69(−) × 98(+) → 6762, sign 1;
  - 255(−) × 98(−) → 24990, sign 0;
  - 999 × 989 → 988011.
- **Full-width operands.** All-ones × all-ones → product_out = 0xFFFFFFFFFFFFFFFE_0000000000000001.
- **Backpressure.** Hold is_ready_in = 0 for 5 cycles after is_valid_out rises → product and tag stay stable and is_ready_out stays 0; raising is_ready_in → is_ready_out = 1 the next cycle.
- **Zero sign and early termination.** 0(+) × 5(−) → product 0, sign 0. Multiplier = 7 → latency 1 cycle with ITERATIVE_MULT_EARLY_TERMINATION_EN, 16 cycles without.
- **Reset mid-operation.** Assert reset_in at BUSY iteration 8 → all outputs 0 immediately. After release, a new 123 × 123 → 15129 with normal latency.
